// File: rtl/picosoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : picosoc_pkg
//  Purpose  : Shared types and constants for the picosoc iomem fabric:
//             fabric FSM state enum, default error read data, default GPSDO
//             peripheral window bases/masks and a select-width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package picosoc_pkg;

  // Fabric handshake states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fabric_state_t;

  // Read data returned to the master on a decode miss or a timeout
  localparam logic [31:0] IOMEM_ERR_RDATA = 32'hDEAD_BEEF;

  // Default GPSDO peripheral windows (256-byte windows)
  localparam logic [31:0] GPSDO_CNT_BASE = 32'h0300_0000;
  localparam logic [31:0] GPSDO_DAC_BASE = 32'h0300_0100;
  localparam logic [31:0] GPSDO_PPS_BASE = 32'h0300_0200;
  localparam logic [31:0] GPSDO_WIN_MASK = 32'hFFFF_FF00;

  // Width of a slave index; a single slave still needs one select bit
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/picosoc_iomem_decode.sv
`default_nettype none
// ============================================================================
//  Module   : picosoc_iomem_decode
//  Purpose  : Combinational priority address decoder. Slave i hits when
//             (addr & mask_i) == (base_i & mask_i); on overlapping windows
//             the lowest index wins.
//  Ports    : addr  in  32             address to decode
//             base  in  NUM_SLAVES*32  packed window bases (slave i at [32*i+:32])
//             mask  in  NUM_SLAVES*32  packed window masks
//             hit   out 1              any window matched
//             sel   out SEL_W          index of the winning window (0 on miss)
//  Revision : 1.0  initial release
// ============================================================================
module picosoc_iomem_decode
  import picosoc_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [31:0]              addr,
  input  logic [NUM_SLAVES*32-1:0] base,
  input  logic [NUM_SLAVES*32-1:0] mask,
  output logic                     hit,
  output logic [SEL_W-1:0]         sel
);

  // Scan from the highest index down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & mask[32*i +: 32]) == (base[32*i +: 32] & mask[32*i +: 32])) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/picosoc_iomem_fabric.sv
`default_nettype none
// ============================================================================
//  Module   : picosoc_iomem_fabric
//  Purpose  : Decodes one master iomem request onto one of NUM_SLAVES address
//             windows, broadcasts the registered request to the slaves and
//             returns the response through a registered single-outstanding
//             handshake. Decode misses and (optionally) timeouts complete as
//             bus errors with ERR_RDATA, an err_irq pulse and a sticky
//             err_addr.
//  Config   : IOMEM_FABRIC_TIMEOUT_EN - when defined, BUSY is bounded to
//             TIMEOUT_CYCLES cycles; when undefined BUSY waits for s_ready.
//  Ports    : clk      in  1              system clock
//             resetn   in  1              asynchronous active-low reset
//             m_valid  in  1              master request
//             m_ready  out 1              one-cycle response strobe
//             m_wstrb  in  4              byte strobes, 0 = read
//             m_addr   in  32             request address
//             m_wdata  in  32             write data
//             m_rdata  out 32             read data, valid while m_ready
//             s_valid  out NUM_SLAVES     one-hot slave request
//             s_ready  in  NUM_SLAVES     slave completion
//             s_wstrb  out 4              registered m_wstrb (broadcast)
//             s_addr   out 32             registered m_addr (broadcast)
//             s_wdata  out 32             registered m_wdata (broadcast)
//             s_rdata  in  NUM_SLAVES*32  packed slave read data
//             err_irq  out 1              one-cycle pulse per error
//             err_addr out 32             address of the latest error (sticky)
//  Revision : 1.0  initial release
// ============================================================================
module picosoc_iomem_fabric
  import picosoc_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] BASE_ADDR      = {4{32'h0300_0000}},
  parameter logic [NUM_SLAVES*32-1:0] ADDR_MASK      = {4{32'hFFFF_FF00}},
  parameter int unsigned              TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_RDATA      = IOMEM_ERR_RDATA
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [3:0]               m_wstrb,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     err_irq,
  output logic [31:0]              err_addr
);

  localparam int unsigned SEL_W = sel_width(NUM_SLAVES);

  fabric_state_t state, state_d;

  logic [SEL_W-1:0]      sel, sel_d;
  logic                  dec_hit;
  logic [SEL_W-1:0]      dec_sel;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic                  rdy_sel;
  logic [31:0]           rdata_sel;
  logic                  timeout;

  logic                  m_ready_d;
  logic [31:0]           m_rdata_d;
  logic [NUM_SLAVES-1:0] s_valid_d;
  logic [3:0]            s_wstrb_d;
  logic [31:0]           s_addr_d;
  logic [31:0]           s_wdata_d;
  logic                  err_irq_d;
  logic [31:0]           err_addr_d;

  picosoc_iomem_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_decode (
    .addr (m_addr),
    .base (BASE_ADDR),
    .mask (ADDR_MASK),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // Selected-slave response mux (only the latched sel is observed, so
  // s_ready of unselected slaves has no effect) and one-hot of the decode.
  always_comb begin
    rdy_sel    = 1'b0;
    rdata_sel  = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_W'(i)) begin
        rdy_sel   = s_ready[i];
        rdata_sel = s_rdata[32*i +: 32];
      end
      if (dec_sel == SEL_W'(i)) begin
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef IOMEM_FABRIC_TIMEOUT_EN
  localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count, count_d;

  // Counter is held at zero in IDLE so it starts clean on entry to BUSY.
  // It stops at CNT_LIMIT because reaching it forces the exit from BUSY.
  always_comb begin
    count_d = count;
    timeout = 1'b0;
    if (state == ST_IDLE) begin
      count_d = '0;
    end else if (state == ST_BUSY && !rdy_sel) begin
      count_d = count + 1'b1;
      timeout = (count_d == CNT_LIMIT);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and next-output logic. Every output is a register, so the
  // values computed here appear one cycle after the deciding event.
  always_comb begin
    state_d    = state;
    sel_d      = sel;
    m_ready_d  = 1'b0;
    m_rdata_d  = m_rdata;
    s_valid_d  = s_valid;
    s_wstrb_d  = s_wstrb;
    s_addr_d   = s_addr;
    s_wdata_d  = s_wdata;
    err_irq_d  = 1'b0;
    err_addr_d = err_addr;

    case (state)
      ST_IDLE: begin
        if (m_valid) begin
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_wstrb_d = m_wstrb;
          if (dec_hit) begin
            sel_d     = dec_sel;
            s_valid_d = sel_onehot;
            state_d   = ST_BUSY;
          end else begin
            // Decode miss: respond straight away; s_addr is being loaded
            // on this same edge, so record the incoming address directly.
            m_ready_d  = 1'b1;
            m_rdata_d  = ERR_RDATA;
            err_irq_d  = 1'b1;
            err_addr_d = m_addr;
            state_d    = ST_DONE;
          end
        end
      end

      ST_BUSY: begin
        // s_ready is checked first so it wins over a coincident timeout
        if (rdy_sel) begin
          s_valid_d = '0;
          m_ready_d = 1'b1;
          m_rdata_d = rdata_sel;
          state_d   = ST_DONE;
        end else if (timeout) begin
          s_valid_d  = '0;
          m_ready_d  = 1'b1;
          m_rdata_d  = ERR_RDATA;
          err_irq_d  = 1'b1;
          err_addr_d = s_addr;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        s_valid_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel      <= '0;
      m_ready  <= 1'b0;
      m_rdata  <= '0;
      s_valid  <= '0;
      s_wstrb  <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      err_irq  <= 1'b0;
      err_addr <= '0;
    end else begin
      sel      <= sel_d;
      m_ready  <= m_ready_d;
      m_rdata  <= m_rdata_d;
      s_valid  <= s_valid_d;
      s_wstrb  <= s_wstrb_d;
      s_addr   <= s_addr_d;
      s_wdata  <= s_wdata_d;
      err_irq  <= err_irq_d;
      err_addr <= err_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_picosoc_iomem_fabric.sv
`default_nettype none
// ============================================================================
//  Module   : tb_picosoc_iomem_fabric
//  Purpose  : Directed self-checking bench for picosoc_iomem_fabric.
//             Windows: slave0 0x0300_00xx, slave1 0x0300_01xx,
//             slave2 0x0300_02xx, slave3 0x0300_xxxx (overlaps 0..2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_picosoc_iomem_fabric;

  localparam int unsigned NS = 4;
  localparam logic [NS*32-1:0] TB_BASE = {32'h0300_0000, 32'h0300_0200,
                                          32'h0300_0100, 32'h0300_0000};
  localparam logic [NS*32-1:0] TB_MASK = {32'hFFFF_0000, 32'hFFFF_FF00,
                                          32'hFFFF_FF00, 32'hFFFF_FF00};
  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h1234_5678;
  localparam logic [31:0] D2 = 32'h2222_2222;
  localparam logic [31:0] D3 = 32'h3333_3333;

  logic           clk = 1'b0;
  logic           resetn;
  logic           m_valid;
  logic           m_ready;
  logic [3:0]     m_wstrb;
  logic [31:0]    m_addr;
  logic [31:0]    m_wdata;
  logic [31:0]    m_rdata;
  logic [NS-1:0]  s_valid;
  logic [NS-1:0]  s_ready;
  logic [3:0]     s_wstrb;
  logic [31:0]    s_addr;
  logic [31:0]    s_wdata;
  logic [NS*32-1:0] s_rdata;
  logic           err_irq;
  logic [31:0]    err_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  picosoc_iomem_fabric #(
    .NUM_SLAVES     (NS),
    .BASE_ADDR      (TB_BASE),
    .ADDR_MASK      (TB_MASK),
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_wstrb  (m_wstrb),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_wstrb  (s_wstrb),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .err_irq  (err_irq),
    .err_addr (err_addr)
  );

  // Advance to 1 time unit after the next rising edge (next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] ws);
    m_valid = 1'b1;
    m_addr  = a;
    m_wdata = d;
    m_wstrb = ws;
  endtask

  task automatic idle_master();
    m_valid = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_master();
    s_ready = '0;
    tick();
    tick();
    n_cmp++;
    if ({m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, err_irq, err_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: m_ready=%b m_rdata=%h s_valid=%b s_addr=%h s_wdata=%h s_wstrb=%b err_irq=%b err_addr=%h, required all 0",
               m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, err_irq, err_addr);
    end
    resetn = 1'b1;
    tick();
  endtask

  // Read slave 1; s_ready[1] at cycle 3, stray s_ready[2] at cycle 1.
  task automatic test_read();
    int early_bad = 0;
    request(32'h0300_0104, 32'h0, 4'b0000);
    tick();                                   // cycle 1
    n_cmp++;
    if (s_valid !== 4'b0010 || s_addr !== 32'h0300_0104) begin
      n_bad++;
      $display("FAIL read_svalid: s_valid=%b s_addr=%h, required 0010 03000104", s_valid, s_addr);
    end
    s_ready = 4'b0100;                        // unselected slave, ignored
    for (int c = 2; c <= 3; c++) begin
      tick();
      if (c == 2) s_ready = 4'b0000;
      if (m_ready !== 1'b0 || s_valid !== 4'b0010) early_bad++;
    end
    n_cmp++;
    if (early_bad !== 0) begin
      n_bad++;
      $display("FAIL read_busy_hold: bad cycles=%0d, required 0", early_bad);
    end
    s_ready = 4'b0010;                        // cycle 3
    tick();                                   // cycle 4
    s_ready = 4'b0000;
    idle_master();
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== D1 || err_irq !== 1'b0 || s_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL read_resp: m_ready=%b m_rdata=%h err_irq=%b s_valid=%b, required 1 %h 0 0000",
               m_ready, m_rdata, err_irq, s_valid, D1);
    end
    tick();                                   // cycle 5
    n_cmp++;
    if (m_ready !== 1'b0 || err_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL read_strobe_len: m_ready=%b err_irq=%b, required 0 0", m_ready, err_irq);
    end
  endtask

  // Write to slave 0 with s_ready already high: minimum 2-cycle latency.
  task automatic test_write();
    request(32'h0300_0010, 32'hA5A5_A5A5, 4'b0011);
    s_ready = 4'b0001;
    tick();                                   // cycle 1
    n_cmp++;
    if (s_valid !== 4'b0001 || s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'b0011 ||
        s_addr !== 32'h0300_0010 || m_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL write_bcast: s_valid=%b s_wdata=%h s_wstrb=%b s_addr=%h m_ready=%b, required 0001 a5a5a5a5 0011 03000010 0",
               s_valid, s_wdata, s_wstrb, s_addr, m_ready);
    end
    tick();                                   // cycle 2
    s_ready = '0;
    idle_master();
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== D0 || s_valid !== 4'b0000 || err_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL write_resp: m_ready=%b m_rdata=%h s_valid=%b err_irq=%b, required 1 %h 0000 0",
               m_ready, m_rdata, s_valid, err_irq, D0);
    end
    tick();
  endtask

  task automatic test_miss();
    request(32'h0400_0000, 32'h0, 4'b0000);
    tick();                                   // cycle 1
    idle_master();
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== 32'hDEAD_BEEF || err_irq !== 1'b1 ||
        err_addr !== 32'h0400_0000 || s_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL miss_resp: m_ready=%b m_rdata=%h err_irq=%b err_addr=%h s_valid=%b, required 1 deadbeef 1 04000000 0000",
               m_ready, m_rdata, err_irq, err_addr, s_valid);
    end
    tick();                                   // cycle 2
    n_cmp++;
    if (m_ready !== 1'b0 || err_irq !== 1'b0 || err_addr !== 32'h0400_0000) begin
      n_bad++;
      $display("FAIL miss_after: m_ready=%b err_irq=%b err_addr=%h, required 0 0 04000000",
               m_ready, err_irq, err_addr);
    end
  endtask

  // Overlapping windows: 0x0300_0204 hits slaves 2 and 3 -> slave 2 wins;
  // 0x0300_0404 hits only slave 3.
  task automatic test_priority();
    request(32'h0300_0204, 32'h0, 4'b0000);
    s_ready = 4'b1100;
    tick();
    n_cmp++;
    if (s_valid !== 4'b0100) begin
      n_bad++;
      $display("FAIL prio_overlap: s_valid=%b, required 0100", s_valid);
    end
    tick();
    idle_master();
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== D2) begin
      n_bad++;
      $display("FAIL prio_overlap_data: m_ready=%b m_rdata=%h, required 1 %h", m_ready, m_rdata, D2);
    end
    tick();
    request(32'h0300_0404, 32'h0, 4'b0000);
    tick();
    n_cmp++;
    if (s_valid !== 4'b1000) begin
      n_bad++;
      $display("FAIL prio_wide: s_valid=%b, required 1000", s_valid);
    end
    tick();
    idle_master();
    s_ready = '0;
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== D3) begin
      n_bad++;
      $display("FAIL prio_wide_data: m_ready=%b m_rdata=%h, required 1 %h", m_ready, m_rdata, D3);
    end
    tick();
  endtask

  // Master replaces m_valid with a new request on the m_ready cycle.
  task automatic test_back_to_back();
    request(32'h0300_0104, 32'h0, 4'b0000);
    s_ready = 4'b0010;
    tick();                                   // cycle 1
    tick();                                   // cycle 2: m_ready for A
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== D1) begin
      n_bad++;
      $display("FAIL b2b_first: m_ready=%b m_rdata=%h, required 1 %h", m_ready, m_rdata, D1);
    end
    request(32'h0300_0208, 32'h0, 4'b0000);
    s_ready = 4'b0100;
    tick();                                   // cycle 3: IDLE
    n_cmp++;
    if (m_ready !== 1'b0 || s_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL b2b_gap: m_ready=%b s_valid=%b, required 0 0000", m_ready, s_valid);
    end
    tick();                                   // cycle 4
    n_cmp++;
    if (s_valid !== 4'b0100 || s_addr !== 32'h0300_0208) begin
      n_bad++;
      $display("FAIL b2b_second_req: s_valid=%b s_addr=%h, required 0100 03000208", s_valid, s_addr);
    end
    tick();                                   // cycle 5
    idle_master();
    s_ready = '0;
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== D2 || err_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second_resp: m_ready=%b m_rdata=%h err_irq=%b, required 1 %h 0",
               m_ready, m_rdata, err_irq, D2);
    end
    tick();
  endtask

`ifdef IOMEM_FABRIC_TIMEOUT_EN
  task automatic test_timeout();
    int hi_cycles = 0;
    request(32'h0300_0104, 32'h0, 4'b0000);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (s_valid === 4'b0010 && m_ready === 1'b0) hi_cycles++;
    end
    tick();                                   // cycle 9
    idle_master();
    n_cmp++;
    if (hi_cycles !== 8) begin
      n_bad++;
      $display("FAIL timeout_svalid_len: cycles=%0d, required 8", hi_cycles);
    end
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== 32'hDEAD_BEEF || err_irq !== 1'b1 ||
        err_addr !== 32'h0300_0104 || s_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL timeout_resp: m_ready=%b m_rdata=%h err_irq=%b err_addr=%h s_valid=%b, required 1 deadbeef 1 03000104 0000",
               m_ready, m_rdata, err_irq, err_addr, s_valid);
    end
    tick();
    n_cmp++;
    if (err_irq !== 1'b0 || m_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: err_irq=%b m_ready=%b, required 0 0", err_irq, m_ready);
    end
  endtask

  // s_ready on the very cycle the counter would expire.
  task automatic test_ready_at_timeout();
    request(32'h0300_0104, 32'h0, 4'b0000);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) s_ready = 4'b0010;
    end
    tick();                                   // cycle 9
    s_ready = '0;
    idle_master();
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== D1 || err_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_at_timeout: m_ready=%b m_rdata=%h err_irq=%b, required 1 %h 0",
               m_ready, m_rdata, err_irq, D1);
    end
    tick();
  endtask
`else
  // Without the timeout feature BUSY must wait well past TIMEOUT_CYCLES.
  task automatic test_no_timeout();
    int hi_cycles = 0;
    request(32'h0300_0104, 32'h0, 4'b0000);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (s_valid === 4'b0010 && m_ready === 1'b0 && err_irq === 1'b0) hi_cycles++;
    end
    n_cmp++;
    if (hi_cycles !== 20) begin
      n_bad++;
      $display("FAIL no_timeout_wait: cycles=%0d, required 20", hi_cycles);
    end
    s_ready = 4'b0010;
    tick();
    s_ready = '0;
    idle_master();
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== D1 || err_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL no_timeout_resp: m_ready=%b m_rdata=%h err_irq=%b, required 1 %h 0",
               m_ready, m_rdata, err_irq, D1);
    end
    tick();
  endtask
`endif

  // Asynchronous reset while BUSY, then a normal access.
  task automatic test_reset_mid();
    request(32'h0300_0104, 32'h0, 4'b0000);
    tick();
    tick();                                   // BUSY, s_valid high
    #2;
    resetn = 1'b0;
    #1;                                       // still before the next edge
    n_cmp++;
    if ({m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, err_irq, err_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: m_ready=%b m_rdata=%h s_valid=%b s_addr=%h err_irq=%b err_addr=%h, required all 0",
               m_ready, m_rdata, s_valid, s_addr, err_irq, err_addr);
    end
    idle_master();
    tick();
    resetn = 1'b1;
    tick();
    request(32'h0300_0020, 32'h0, 4'b0000);
    s_ready = 4'b0001;
    tick();
    tick();
    idle_master();
    s_ready = '0;
    n_cmp++;
    if (m_ready !== 1'b1 || m_rdata !== D0 || err_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_recover: m_ready=%b m_rdata=%h err_irq=%b, required 1 %h 0",
               m_ready, m_rdata, err_irq, D0);
    end
    tick();
  endtask

  initial begin
    s_rdata = {D3, D2, D1, D0};
    test_reset();
    test_read();
    test_write();
    test_miss();
    test_priority();
    test_back_to_back();
`ifdef IOMEM_FABRIC_TIMEOUT_EN
    test_timeout();
    test_ready_at_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/picosoc_iomem_fabric.md
# picosoc_iomem_fabric

- Parametrised successor to the single-window iomem decode in the picosoc top.
- Decodes one master iomem request to one of `NUM_SLAVES` address windows and broadcasts the request to the selected slave.
- Returns the response through a registered, single-outstanding handshake.
- Bounds every access with a timeout and reports decode misses and timeouts as bus errors.
- Sits between the CPU-side iomem port and external peripherals (GPSDO counters, DAC, PPS capture).

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of slave windows, 1..16.
- `BASE_ADDR`, {4{32'h0300_0000}}: packed `NUM_SLAVES*32` window bases; slave i uses bits [32*i+:32].
- `ADDR_MASK`, {4{32'hFFFF_FF00}}: packed `NUM_SLAVES*32` masks. Slave i hits when (m_addr & mask_i) == (base_i & mask_i).
- `TIMEOUT_CYCLES`, 255: maximum BUSY cycles before timeout, 1..65535.
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned on any error.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: reset. Asynchronous, active-low; one clock domain.
- `m_valid` in 1: master request.
- `m_ready` out 1: one-cycle response strobe.
- `m_wstrb` in 4: byte strobes; 0 means read.
- `m_addr` in 32: request address.
- `m_wdata` in 32: write data.
- `m_rdata` out 32: read data, valid while m_ready.
- `s_valid` out NUM_SLAVES: one-hot slave request.
- `s_ready` in NUM_SLAVES: slave completion.
- `s_wstrb` out 4: registered copy of m_wstrb, broadcast to all slaves.
- `s_addr` out 32: registered copy of m_addr, broadcast to all slaves.
- `s_wdata` out 32: registered copy of m_wdata, broadcast to all slaves.
- `s_rdata` in NUM_SLAVES*32: packed slave read data.
- `err_irq` out 1: one-cycle pulse on each error, for wiring to irq_5..7.
- `err_addr` out 32: address of the most recent error (sticky).

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**, m_valid=1:
  - Latch m_addr, m_wdata, m_wstrb into the s_* registers.
  - Decode by priority: the lowest index wins on overlapping windows.
  - On a hit: latch `sel`, go to BUSY.
  - On a miss: set err, go to DONE.
- **BUSY**:
  - s_valid[sel]=1; all other s_valid bits are 0.
  - On s_ready[sel]: capture s_rdata[sel] into the rdata register, go to DONE.
  - s_ready bits of unselected slaves are ignored.
  - Timeout counter increments each BUSY cycle. When it reaches TIMEOUT_CYCLES with no s_ready: deassert s_valid, set err, go to DONE.
  - If s_ready[sel] arrives in the same cycle as the timeout, s_ready wins and there is no error.
- **DONE**:
  - m_ready=1 for exactly one cycle.
  - m_rdata = captured data, or ERR_RDATA if err.
  - If err: err_irq=1 and err_addr<=s_addr.
  - Go to IDLE unconditionally. The master must drop or replace m_valid on the cycle after m_ready.
- On error, write data is discarded.
- Reset mid-operation: FSM returns to IDLE and the in-flight access is abandoned. Slaves must tolerate s_valid falling without ready.

## Timing
- Reset values: m_ready=0, m_rdata=0, s_valid=0, s_addr/s_wdata/s_wstrb=0, err_irq=0, err_addr=0, counter=0, state IDLE.
- All outputs are registered. There is no combinational path from m_* to s_* or from s_* to m_*.
- Cycle numbering, with m_valid first seen at cycle 0:
  - s_valid rises at cycle 1.
  - If s_ready is seen at cycle k, m_ready is high at cycle k+1.
  - Minimum latency is 2 cycles (s_ready already high at cycle 1).
- Timeout: s_valid is high for TIMEOUT_CYCLES cycles, and m_ready follows on the next cycle.
- Decode miss: m_ready at cycle 1.
- Counter width: clog2(TIMEOUT_CYCLES+1). The counter clears on entry to BUSY and never wraps.

## Configuration
- `IOMEM_FABRIC_TIMEOUT_EN` defined: timeout counter and timeout error path are present, as above.
- Undefined: the counter is not built, BUSY waits indefinitely for s_ready, and TIMEOUT_CYCLES is ignored. Only decode misses raise an error.

## Structure
- `picosoc_pkg` holds:
  - the fabric state enum (IDLE/BUSY/DONE);
  - the `ERR_RDATA` default constant;
  - the default GPSDO peripheral base/mask constants.
- One sub-module, `picosoc_iomem_decode`: combinational priority decoder. Inputs are address and packed base/mask; outputs are hit and the sel index. It is reused by future fabrics.

## Test plan
- Read slave 1 at 32'h0300_0104, s_ready[1] at cycle 3, s_rdata=32'h1234_5678 -> m_ready at cycle 4, m_rdata=32'h1234_5678, err_irq stays 0.
- Write 32'hA5A5_A5A5 with wstrb 4'b0011 to slave 0 -> s_valid=4'b0001 and s_wdata/s_wstrb match while BUSY; no other s_valid bit asserts.
- Access 32'h0400_0000 (no window hit) -> m_ready at cycle 1, m_rdata=32'hDEAD_BEEF, err_irq pulses once, err_addr=32'h0400_0000.
- With the macro defined and TIMEOUT_CYCLES=8, slave never readies -> s_valid high for exactly 8 cycles, then m_ready with 32'hDEAD_BEEF and an err_irq pulse.
- s_ready[sel] asserted in the same cycle as the timeout -> slave data returned, no err_irq.
- resetn pulled low while in BUSY -> all outputs are 0 immediately (asynchronously). After release, a normal access completes with correct data.
